// File: rtl/fifo_sync_flex_if.sv
// Bundle of the producer/consumer side signals of fifo_sync_flex.
// master: the surrounding logic that writes, reads, flushes and observes.
// slave : the FIFO itself.
interface fifo_sync_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  i_write;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_read;
    logic                  i_flush;
    logic                  i_clear_err;

    logic                  o_wr_full;
    logic                  o_wr_almost_full;
    logic                  o_rd_empty;
    logic                  o_rd_almost_empty;
    logic [CW-1:0]         o_count;
    logic [DATA_WIDTH-1:0] ow_rd_data;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_write, i_wr_data, i_read, i_flush, i_clear_err,
        input  o_wr_full, o_wr_almost_full, o_rd_empty, o_rd_almost_empty,
        input  o_count, ow_rd_data, o_rd_data, o_overflow, o_underflow
    );

    modport slave (
        input  i_write, i_wr_data, i_read, i_flush, i_clear_err,
        output o_wr_full, o_wr_almost_full, o_rd_empty, o_rd_almost_empty,
        output o_count, ow_rd_data, o_rd_data, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO of arbitrary depth (>= 2) with explicit pointer wrap,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
//
// Handshake: a write is accepted on a rising clock edge when i_write=1,
// o_wr_full=0 and i_flush=0; a read is accepted when i_read=1,
// o_rd_empty=0 and i_flush=0. Requests that are not accepted are dropped
// (not held); a dropped write or read outside a flush raises the matching
// sticky error flag. ow_rd_data shows the head entry (fall-through);
// o_rd_data is the same head entry delayed by one clock.
module fifo_sync_flex #(
    parameter int DEL              = 1,
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 5,
    parameter int ALMOST_WR_MARGIN = 1,
    parameter int ALMOST_RD_MARGIN = 1,
    parameter     INSTANCE_NAME    = "DEADF1F0"
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fifo_sync_flex_if.slave bus
);
    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Elaboration-time guard against illegal geometry.
    if (DEPTH < 2 || ALMOST_WR_MARGIN < 1 || ALMOST_WR_MARGIN > DEPTH - 1 ||
        ALMOST_RD_MARGIN < 1 || ALMOST_RD_MARGIN > DEPTH - 1) begin : g_bad_params
        $error("%s: illegal DEPTH/ALMOST margins (DEL=%0d)", INSTANCE_NAME, DEL);
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wv;
    logic                  w_rv;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [AW-1:0]         w_wr_ptr_next;
    logic [AW-1:0]         w_rd_ptr_next;
    logic [CW-1:0]         w_count_next;

    // Pointers wrap by compare against DEPTH-1, never by bit truncation.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Accept/reject decode and next-state of pointers and count.
    always_comb begin
        w_wv          = bus.i_write & ~r_full  & ~bus.i_flush;
        w_rv          = bus.i_read  & ~r_empty & ~bus.i_flush;
        w_ovf_set     = bus.i_write &  r_full  & ~bus.i_flush;
        w_udf_set     = bus.i_read  &  r_empty & ~bus.i_flush;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (bus.i_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_wv) w_wr_ptr_next = ptr_inc(r_wr_ptr);
            if (w_rv) w_rd_ptr_next = ptr_inc(r_rd_ptr);
            w_count_next = r_count + CW'(w_wv) - CW'(w_rv);
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wv) r_mem[r_wr_ptr] <= bus.i_wr_data;
    end

    // Pointers, count, status flags (decoded from next count) and error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_data      <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_full         <= (w_count_next == CW'(DEPTH));
            r_almost_full  <= (w_count_next >= CW'(DEPTH - ALMOST_WR_MARGIN));
            r_empty        <= (w_count_next == '0);
            r_almost_empty <= (w_count_next <= CW'(ALMOST_RD_MARGIN));
            r_rd_data      <= r_mem[r_rd_ptr];
            // Set wins over clear when both happen in one cycle.
            r_overflow     <= w_ovf_set | (r_overflow  & ~bus.i_clear_err);
            r_underflow    <= w_udf_set | (r_underflow & ~bus.i_clear_err);
        end
    end

    assign bus.o_wr_full         = r_full;
    assign bus.o_wr_almost_full  = r_almost_full;
    assign bus.o_rd_empty        = r_empty;
    assign bus.o_rd_almost_empty = r_almost_empty;
    assign bus.o_count           = r_count;
    assign bus.ow_rd_data        = r_mem[r_rd_ptr];
    assign bus.o_rd_data         = r_rd_data;
    assign bus.o_overflow        = r_overflow;
    assign bus.o_underflow       = r_underflow;
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Self-checking bench for fifo_sync_flex at DEPTH=5, DATA_WIDTH=8.
module tb_fifo_sync_flex;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    fifo_sync_flex_if #(.DATA_WIDTH(8), .DEPTH(5)) bus ();

    fifo_sync_flex #(
        .DEL(1), .DATA_WIDTH(8), .DEPTH(5),
        .ALMOST_WR_MARGIN(1), .ALMOST_RD_MARGIN(1), .INSTANCE_NAME("DEADF1F0")
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Driver: apply one cycle of requests, return 1ns after the edge with inputs idle.
    task automatic drive_cycle(input logic w, input logic [7:0] d, input logic r,
                               input logic f, input logic c);
        bus.i_write     = w;
        bus.i_wr_data   = d;
        bus.i_read      = r;
        bus.i_flush     = f;
        bus.i_clear_err = c;
        @(posedge clk);
        #1;
        bus.i_write     = 1'b0;
        bus.i_read      = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_clear_err = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_rd_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.o_rd_empty); end
        n_cmp++; if (bus.o_rd_almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %b want 1", bus.o_rd_almost_empty); end
        n_cmp++; if (bus.o_wr_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.o_wr_full); end
        n_cmp++; if (bus.o_wr_almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", bus.o_wr_almost_full); end
        n_cmp++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", bus.o_overflow, bus.o_underflow); end
        n_cmp++; if (bus.o_rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", bus.o_rd_data); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(8'(8'h10 + i));
            if (i == 0) begin
                n_cmp++; if (bus.o_rd_empty !== 1'b0 || bus.ow_rd_data !== 8'h10) begin n_err++; $display("FAIL first_write_visible: got empty=%b data=%h want 0/10", bus.o_rd_empty, bus.ow_rd_data); end
            end
            if (i == 3) begin
                n_cmp++; if (bus.o_wr_almost_full !== 1'b1 || bus.o_wr_full !== 1'b0) begin n_err++; $display("FAIL afull_at4: got afull=%b full=%b want 1/0", bus.o_wr_almost_full, bus.o_wr_full); end
            end
        end
        n_cmp++; if (bus.o_wr_full !== 1'b1 || bus.o_count !== 3'd5) begin n_err++; $display("FAIL full_at5: got full=%b count=%0d want 1/5", bus.o_wr_full, bus.o_count); end
        n_cmp++; if (bus.o_rd_data !== 8'h10) begin n_err++; $display("FAIL rd_data_reg: got %h want 10", bus.o_rd_data); end
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.o_overflow !== 1'b1 || bus.o_count !== 3'd5) begin n_err++; $display("FAIL overflow: got ovf=%b count=%0d want 1/5", bus.o_overflow, bus.o_count); end
        for (int i = 0; i < 5; i++) begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL fill_read: got %h want %h", bus.ow_rd_data, exp_v); end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (bus.o_rd_empty !== 1'b1 || bus.o_count !== 3'd0) begin n_err++; $display("FAIL drained: got empty=%b count=%0d want 1/0", bus.o_rd_empty, bus.o_count); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.o_overflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        d = 8'h40;
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(d);
                d = d + 8'd1;
            end
            for (int i = 0; i < 3; i++) begin
                exp_v = exp_q.pop_front();
                n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL wrap_data: got %h want %h", bus.ow_rd_data, exp_v); end
                drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            end
            n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", bus.o_count); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(8'(8'h60 + i));
        end
        // full: read pops, write is dropped
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL rw_full_head: got %h want %h", bus.ow_rd_data, exp_v); end
        drive_cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.o_count !== 3'd4 || bus.o_overflow !== 1'b1) begin n_err++; $display("FAIL rw_full: got count=%0d ovf=%b want 4/1", bus.o_count, bus.o_overflow); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL rw_full_drain: got %h want %h", bus.ow_rd_data, exp_v); end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        // empty: read dropped, write accepted
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h77);
        n_cmp++; if (bus.o_count !== 3'd1 || bus.o_underflow !== 1'b1) begin n_err++; $display("FAIL rw_empty: got count=%0d udf=%b want 1/1", bus.o_count, bus.o_underflow); end
        drive_cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h78);
        // count 2: both accepted, count holds
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL rw_mid_head: got %h want %h", bus.ow_rd_data, exp_v); end
        drive_cycle(1'b1, 8'h79, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h79);
        n_cmp++; if (bus.o_count !== 3'd2) begin n_err++; $display("FAIL rw_mid: got count=%0d want 2", bus.o_count); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (bus.ow_rd_data !== exp_v) begin n_err++; $display("FAIL rw_mid_drain: got %h want %h", bus.ow_rd_data, exp_v); end
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin n_err++; $display("FAIL rw_clear: got %b%b want 00", bus.o_overflow, bus.o_underflow); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(8'(8'hA0 + i));
        end
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        exp_q.delete();
        n_cmp++; if (bus.o_count !== 3'd0 || bus.o_rd_empty !== 1'b1) begin n_err++; $display("FAIL flush_state: got count=%0d empty=%b want 0/1", bus.o_count, bus.o_rd_empty); end
        n_cmp++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin n_err++; $display("FAIL flush_err: got %b%b want 00", bus.o_overflow, bus.o_underflow); end
        drive_cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'hAB);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.ow_rd_data !== exp_v || bus.o_rd_empty !== 1'b0) begin n_err++; $display("FAIL flush_after: got data=%h empty=%b want %h/0", bus.ow_rd_data, bus.o_rd_empty, exp_v); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL flush_drain: got %0d want 0", bus.o_count); end
    endtask

    task automatic test_clear_err();
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.o_underflow !== 1'b1) begin n_err++; $display("FAIL udf_set: got %b want 1", bus.o_underflow); end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (bus.o_underflow !== 1'b1) begin n_err++; $display("FAIL udf_set_dominant: got %b want 1", bus.o_underflow); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.o_underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear: got %b want 0", bus.o_underflow); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        // mid-burst: request still asserted, reset dropped between edges
        bus.i_write   = 1'b1;
        bus.i_wr_data = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_count !== 3'd0 || bus.o_rd_empty !== 1'b1 || bus.o_rd_almost_empty !== 1'b1) begin n_err++; $display("FAIL async_count: got count=%0d empty=%b aempty=%b want 0/1/1", bus.o_count, bus.o_rd_empty, bus.o_rd_almost_empty); end
        n_cmp++; if (bus.o_wr_full !== 1'b0 || bus.o_wr_almost_full !== 1'b0 || bus.o_overflow !== 1'b0 || bus.o_rd_data !== 8'h00) begin n_err++; $display("FAIL async_flags: got full=%b afull=%b ovf=%b rd=%h want 0/0/0/00", bus.o_wr_full, bus.o_wr_almost_full, bus.o_overflow, bus.o_rd_data); end
        bus.i_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h3C);
        exp_v = exp_q.pop_front();
        n_cmp++; if (bus.ow_rd_data !== exp_v || bus.o_count !== 3'd1) begin n_err++; $display("FAIL post_reset_write: got data=%h count=%0d want %h/1", bus.ow_rd_data, bus.o_count, exp_v); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_write     = 1'b0;
        bus.i_wr_data   = 8'h00;
        bus.i_read      = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_clear_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_clear_err();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
